mux_4_rr_arbiter: RTL and testbench

//  Shares one W-bit output channel among 4 requesters using round-robin arbitration

---
 rtl/mux_arb_pkg.sv | 13 +
 rtl/mux_4_1.sv | 26 ++
 rtl/rr_pick_4.sv | 30 +++
 rtl/mux_4_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_mux_4_rr_arbiter.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4-way round-robin output arbiter.
package mux_arb_pkg;

    localparam int N_REQ = 4;

    typedef logic [1:0] src_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage : mux_arb_pkg

// File: rtl/mux_4_1.sv
// Team 4:1 data multiplexer, W bits wide, selected by a 2-bit source index.
module mux_4_1
    import mux_arb_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] i_d0,
    input  logic [W-1:0] i_d1,
    input  logic [W-1:0] i_d2,
    input  logic [W-1:0] i_d3,
    input  logic [1:0]   i_sel,
    output logic [W-1:0] o_y
);

    // Pass the selected input straight through.
    always_comb begin
        o_y = i_d0;
        case (i_sel)
            2'd0: o_y = i_d0;
            2'd1: o_y = i_d1;
            2'd2: o_y = i_d2;
            2'd3: o_y = i_d3;
        endcase
    end

endmodule : mux_4_1

// File: rtl/rr_pick_4.sv
// Rotating-priority picker: first set request bit scanning from i_ptr upward, wrapping mod 4.
module rr_pick_4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [1:0]       i_ptr,
    output logic             o_any,
    output logic [1:0]       o_sel
);

    src_t w_idx;
    logic w_found;

    // Walk the four positions starting at the pointer; the first hit wins.
    always_comb begin
        o_sel   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = i_ptr + src_t'(k);
            if (!w_found && i_req[w_idx]) begin
                o_sel   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule : rr_pick_4

// File: rtl/mux_4_rr_arbiter.sv
// Four producers share one registered valid/ready output channel with round-robin
// arbitration and bounded bursts.
//
//   state | meaning
//   IDLE  | no lock; next winner found by scanning from r_ptr
//   BURST | r_cur owns the channel while valid, r_beats_left beats still allowed
module mux_4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int W         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req_valid,
    input  logic [W-1:0]     i_req_data0,
    input  logic [W-1:0]     i_req_data1,
    input  logic [W-1:0]     i_req_data2,
    input  logic [W-1:0]     i_req_data3,
    output logic [N_REQ-1:0] o_req_ready,
    output logic             o_out_valid,
    output logic [W-1:0]     o_out_data,
    output logic [1:0]       o_out_src,
    input  logic             i_out_ready
);

    // Wide enough to hold MAX_BURST-1 even when MAX_BURST is 1.
    localparam int              BL_W    = $clog2(MAX_BURST) + 1;
    localparam logic [BL_W-1:0] BL_INIT = BL_W'(MAX_BURST - 1);

    arb_state_t      r_state;
    src_t            r_ptr;
    src_t            r_cur;
    logic [BL_W-1:0] r_beats_left;
    logic            r_out_valid;
    logic [W-1:0]    r_out_data;
    src_t            r_out_src;

    logic            w_owner_hold;
    src_t            w_pick_ptr;
    src_t            w_pick_sel;
    src_t            w_sel;
    logic            w_any;
    logic            w_free;
    logic            w_load;
    logic [W-1:0]    w_mux_data;

    // A live owner keeps the channel; if it drops out, scanning restarts just past it.
    assign w_owner_hold = (r_state == BURST) && i_req_valid[r_cur];
    assign w_pick_ptr   = (r_state == BURST) ? r_cur + src_t'(1) : r_ptr;

    rr_pick_4 u_pick (
        .i_req (i_req_valid),
        .i_ptr (w_pick_ptr),
        .o_any (w_any),
        .o_sel (w_pick_sel)
    );

    assign w_sel  = w_owner_hold ? r_cur : w_pick_sel;
    assign w_free = ~r_out_valid | i_out_ready;
    // Gated by reset so no requester sees an accept while the block is held in reset.
    assign w_load = i_rst_n & w_free & w_any;

    assign o_req_ready = w_load ? (N_REQ'(1) << w_sel) : '0;

    mux_4_1 #(.W(W)) u_mux (
        .i_d0  (i_req_data0),
        .i_d1  (i_req_data1),
        .i_d2  (i_req_data2),
        .i_d3  (i_req_data3),
        .i_sel (w_sel),
        .o_y   (w_mux_data)
    );

    // Output stage: load replaces the held beat, otherwise drain on ready or hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux_data;
            r_out_src   <= w_sel;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Arbitration FSM: only advances on an accepted beat, so stalls never lose or repeat one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_cur        <= '0;
            r_beats_left <= '0;
        end else if (w_load) begin
            case (r_state)
                IDLE: begin
                    if (MAX_BURST > 1) begin
                        r_state      <= BURST;
                        r_cur        <= w_sel;
                        r_beats_left <= BL_INIT;
                    end else begin
                        r_ptr <= w_sel + src_t'(1);
                    end
                end
                BURST: begin
                    if (w_owner_hold) begin
                        if (r_beats_left <= BL_W'(1)) begin
                            r_state      <= IDLE;
                            r_beats_left <= '0;
                            r_ptr        <= r_cur + src_t'(1);
                        end else begin
                            r_beats_left <= r_beats_left - BL_W'(1);
                        end
                    end else begin
                        // Owner released early: the new winner starts a fresh burst.
                        r_cur        <= w_sel;
                        r_beats_left <= BL_INIT;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_src   = r_out_src;

endmodule : mux_4_rr_arbiter

// File: tb/tb_mux_4_rr_arbiter.sv
// Directed bench for mux_4_rr_arbiter: one instance with MAX_BURST=2, one with MAX_BURST=1.
module tb_mux_4_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_valid;
    logic [3:0] d0, d1, d2, d3;
    logic       out_ready;

    logic [3:0] rdy2, rdy1;
    logic       ov2, ov1;
    logic [3:0] od2, od1;
    logic [1:0] os2, os1;

    int checks = 0;
    int errors = 0;

    mux_4_rr_arbiter #(.W(4), .MAX_BURST(2)) dut2 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_data0 (d0),
        .i_req_data1 (d1),
        .i_req_data2 (d2),
        .i_req_data3 (d3),
        .o_req_ready (rdy2),
        .o_out_valid (ov2),
        .o_out_data  (od2),
        .o_out_src   (os2),
        .i_out_ready (out_ready)
    );

    mux_4_rr_arbiter #(.W(4), .MAX_BURST(1)) dut1 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_data0 (d0),
        .i_req_data1 (d1),
        .i_req_data2 (d2),
        .i_req_data3 (d3),
        .o_req_ready (rdy1),
        .o_out_valid (ov1),
        .o_out_data  (od1),
        .o_out_src   (os1),
        .i_out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] v;
        logic       ordy;
        logic [3:0] er;
        logic       eov;
        logic [1:0] es;
        logic [3:0] ed;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called just after a falling edge: drive, check same-cycle accept, cross the rising edge,
    // then check the registered output. use1 selects the MAX_BURST=1 instance.
    task automatic step(input logic [3:0] v, input logic ordy, input logic [3:0] er,
                        input logic eov, input logic [1:0] es, input logic [3:0] ed,
                        input bit use1, input string name);
        req_valid = v;
        out_ready = ordy;
        #1;
        chk({name, ".req_ready"}, use1 ? rdy1 : rdy2, er);
        @(posedge clk);
        #1;
        chk({name, ".out_valid"}, use1 ? ov1 : ov2, eov);
        if (eov) begin
            chk({name, ".out_src"},  use1 ? os1 : os2, es);
            chk({name, ".out_data"}, use1 ? od1 : od2, ed);
        end
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        req_valid = 4'b0000;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;

        // All valid, after row 7 (src3 second beat) a 3-cycle stall, then service resumes.
        tbl[0]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA};
        tbl[1]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA};
        tbl[2]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB};
        tbl[3]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB};
        tbl[4]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC};
        tbl[5]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC};
        tbl[6]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD};
        tbl[7]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD};
        tbl[8]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd3, 4'hD};
        tbl[9]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd3, 4'hD};
        tbl[10] = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd3, 4'hD};
        tbl[11] = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA};
        tbl[12] = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA};
        tbl[13] = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB};
        tbl[14] = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0};
        tbl[15] = '{4'h0, 1'b0, 4'b0000, 1'b0, 2'd0, 4'h0};

        // Reset state, with every requester asserting valid during reset.
        rst_n = 1'b0;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #2;
        chk("rst.req_ready", rdy2, 4'b0000);
        chk("rst.out_valid", ov2, 1'b0);
        chk("rst.out_src",   os2, 2'd0);
        chk("rst.out_data",  od2, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester.
        step(4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB, 1'b0, "single");

        // Reset asserted between edges while a beat is held.
        chk("midrst.pre_valid", ov2, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", ov2, 1'b0);
        chk("midrst.out_src",   os2, 2'd0);
        chk("midrst.req_ready", rdy2, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin with bursts of two, backpressure and drain.
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].v, tbl[i].ordy, tbl[i].er, tbl[i].eov, tbl[i].es, tbl[i].ed,
                 1'b0, $sformatf("tbl%0d", i));
        end

        // Owner drops valid after one beat; src2 takes a full burst, then src0 again.
        reset_pulse();
        step(4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA, 1'b0, "drop0");
        step(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC, 1'b0, "drop1");
        step(4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC, 1'b0, "drop2");
        step(4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA, 1'b0, "drop3");

        // MAX_BURST=1: serve src2 to park the pointer at 3, then alternate 3/0 across the wrap.
        reset_pulse();
        step(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC, 1'b1, "mb1_0");
        step(4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD, 1'b1, "mb1_1");
        step(4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA, 1'b1, "mb1_2");
        step(4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD, 1'b1, "mb1_3");
        step(4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA, 1'b1, "mb1_4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mux_4_rr_arbiter
